// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the instruction fetch front end.
//   XLEN             - data / address word width
//   IMEM_AW          - instruction memory word-address width
//   RESET_PC_DEFAULT - default fetch address after reset
//   fetch_state_t    - fetch FSM states
//   fetch_entry_t    - one prefetch queue entry (IF/ID pc + instruction)
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int IMEM_AW = 10;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue storage and pointers.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_data at the tail
//   pop        - drop the head entry
//   flush      - empty the queue (wins over push/pop)
//   push_data  - entry to write
//   head       - entry at the read pointer (undefined when count == 0)
//   count      - number of valid entries, 0..DEPTH
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Storage is not reset; the top masks head whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small prefetch queue feeding ID.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (an acked word arriving at an
// empty queue is presented to ID in the same cycle).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   imem_req        - instruction memory read request
//   imem_addr       - word address, fetch_pc[11:2]
//   imem_ack        - read data valid this cycle
//   imem_rdata      - instruction word from memory
//   redirect        - taken branch / jump from EX
//   redirect_pc     - branch target
//   stall           - ID cannot accept an instruction this cycle
//   id_valid        - id_pc / id_instr hold a valid instruction
//   id_pc           - fetch address + 4 of the presented instruction
//   id_instr        - instruction presented to ID
//
// state  | meaning
// S_REQ  | may issue a request (no request outstanding)
// S_WAIT | request outstanding, address held stable until ack
// S_DROP | outstanding response is stale and will be discarded
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               stall,
  output logic               id_valid,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] next_pc;
  logic [CW-1:0]   count;
  logic            room;
  logic            accept;
  logic            push;
  logic            pop;
  logic            queue_valid;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign next_pc     = fetch_pc + 32'd4;
  // In S_REQ nothing is outstanding, so room only depends on count.
  assign room        = (count < CW'(DEPTH));
  assign imem_req    = !rst && (((state == S_REQ) && room) || (state == S_WAIT));
  assign imem_addr   = fetch_pc[IMEM_AW+1:2];
  assign accept      = imem_req && imem_ack;
  assign queue_valid = (count != '0);
  assign push_data   = {next_pc, imem_rdata};
  assign pop         = queue_valid && !stall && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = accept && !redirect && !queue_valid;
  // A bypassed word is consumed directly by ID unless ID is stalled.
  assign push   = accept && !redirect && (!bypass || stall);
`else
  assign push   = accept && !redirect;
`endif

  always_comb begin
    id_valid = queue_valid;
    id_pc    = head.pc;
    id_instr = head.instr;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      id_valid = 1'b1;
      id_pc    = next_pc;
      id_instr = imem_rdata;
    end
`endif
    if (!id_valid) begin
      id_pc    = '0;
      id_instr = '0;
    end
  end

  // A redirect with a request still pending (not acked this cycle) must
  // swallow the eventual response, hence S_DROP from both S_REQ and S_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      case (state)
        S_REQ:   state <= (imem_req && !imem_ack) ? S_DROP : S_REQ;
        S_WAIT:  state <= imem_ack ? S_REQ : S_DROP;
        S_DROP:  state <= imem_ack ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req) begin
            if (imem_ack) begin
              fetch_pc <= next_pc;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            fetch_pc <= next_pc;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  logic        auto_ack;
  logic        man_ack;
  logic [31:0] man_rdata;

  int errors = 0;
  int checks = 0;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
  );

  // Zero-wait memory when auto_ack is set, otherwise ack/data are scripted.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = auto_ack ? (32'hC0DE_0000 | {22'd0, imem_addr}) : man_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    auto_ack = 1'b1; man_ack = 1'b0; man_rdata = '0;

    // Reset values
    tick(); tick();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc",    id_pc, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_addr",  {22'd0, imem_addr}, 32'd0);

    // Zero-wait streaming after reset release
    rst = 1'b0; #1;
    chk("s_c1_req",  {31'd0, imem_req}, 32'd1);
    chk("s_c1_addr", {22'd0, imem_addr}, 32'd0);
    chk("s_c1_vld",  {31'd0, id_valid}, 32'd0);
    tick();
    chk("s_c2_vld",  {31'd0, id_valid}, 32'd1);
    chk("s_c2_pc",   id_pc, 32'd4);
    chk("s_c2_ins",  id_instr, 32'hC0DE_0000);
    chk("s_c2_addr", {22'd0, imem_addr}, 32'd1);
    tick();
    chk("s_c3_pc",   id_pc, 32'd8);
    chk("s_c3_addr", {22'd0, imem_addr}, 32'd2);
    tick();
    chk("s_c4_pc",   id_pc, 32'd12);
    chk("s_c4_addr", {22'd0, imem_addr}, 32'd3);
    tick();
    chk("s_c5_pc",   id_pc, 32'd16);
    chk("s_c5_ins",  id_instr, 32'hC0DE_0003);

    // Stall held: queue fills after 4 requests
    rst = 1'b1; tick(); tick();
    stall = 1'b1; rst = 1'b0; #1;
    chk("f_c1_req",  {31'd0, imem_req}, 32'd1);
    tick();
    chk("f_c2_req",  {31'd0, imem_req}, 32'd1);
    chk("f_c2_pc",   id_pc, 32'd4);
    tick();
    chk("f_c3_addr", {22'd0, imem_addr}, 32'd2);
    tick();
    chk("f_c4_req",  {31'd0, imem_req}, 32'd1);
    chk("f_c4_addr", {22'd0, imem_addr}, 32'd3);
    tick();
    chk("f_c5_req",  {31'd0, imem_req}, 32'd0);
    tick();
    chk("f_c6_req",  {31'd0, imem_req}, 32'd0);
    chk("f_c6_pc",   id_pc, 32'd4);
    chk("f_c6_ins",  id_instr, 32'hC0DE_0000);
    stall = 1'b0;
    tick();
    chk("f_c7_pc",   id_pc, 32'd8);
    chk("f_c7_req",  {31'd0, imem_req}, 32'd1);
    chk("f_c7_addr", {22'd0, imem_addr}, 32'd4);
    tick();
    chk("f_c8_pc",   id_pc, 32'd12);

    // Ack delayed 3 cycles
    rst = 1'b1; tick(); tick();
    auto_ack = 1'b0; man_ack = 1'b0; rst = 1'b0; #1;
    chk("w_c1_req",  {31'd0, imem_req}, 32'd1);
    chk("w_c1_addr", {22'd0, imem_addr}, 32'd0);
    tick();
    chk("w_c2_addr", {22'd0, imem_addr}, 32'd0);
    chk("w_c2_vld",  {31'd0, id_valid}, 32'd0);
    tick();
    chk("w_c3_addr", {22'd0, imem_addr}, 32'd0);
    tick();
    chk("w_c4_req",  {31'd0, imem_req}, 32'd1);
    chk("w_c4_addr", {22'd0, imem_addr}, 32'd0);
    man_ack = 1'b1; man_rdata = 32'h1111_0000;
    tick();
    man_ack = 1'b0;
    chk("w_c5_vld",  {31'd0, id_valid}, 32'd1);
    chk("w_c5_pc",   id_pc, 32'd4);
    chk("w_c5_ins",  id_instr, 32'h1111_0000);
    chk("w_c5_addr", {22'd0, imem_addr}, 32'd1);
    tick();
    chk("w_c6_vld",  {31'd0, id_valid}, 32'd0);
    chk("w_c6_req",  {31'd0, imem_req}, 32'd1);

    // Redirect while in WAIT: stale response dropped
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("d_c7_req",  {31'd0, imem_req}, 32'd0);
    chk("d_c7_addr", {22'd0, imem_addr}, 32'd64);
    chk("d_c7_vld",  {31'd0, id_valid}, 32'd0);
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    chk("d_c8_vld",  {31'd0, id_valid}, 32'd0);
    chk("d_c8_req",  {31'd0, imem_req}, 32'd1);
    chk("d_c8_addr", {22'd0, imem_addr}, 32'd64);
    man_ack = 1'b1; man_rdata = 32'h1234_5678;
    tick();
    man_ack = 1'b0;
    chk("d_c9_vld",  {31'd0, id_valid}, 32'd1);
    chk("d_c9_pc",   id_pc, 32'h0000_0104);
    chk("d_c9_ins",  id_instr, 32'h1234_5678);
    chk("d_c9_addr", {22'd0, imem_addr}, 32'd65);

    // Redirect coincident with ack, queue at capacity, stall high
    stall = 1'b1; auto_ack = 1'b1;
    tick();
    chk("r_c10_addr", {22'd0, imem_addr}, 32'd66);
    tick();
    chk("r_c11_addr", {22'd0, imem_addr}, 32'd67);
    auto_ack = 1'b0;
    tick();
    chk("r_c12_req",  {31'd0, imem_req}, 32'd1);
    chk("r_c12_addr", {22'd0, imem_addr}, 32'd67);
    chk("r_c12_pc",   id_pc, 32'h0000_0104);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();
    redirect = 1'b0; man_ack = 1'b0;
    chk("r_c13_vld",  {31'd0, id_valid}, 32'd0);
    chk("r_c13_req",  {31'd0, imem_req}, 32'd1);
    chk("r_c13_addr", {22'd0, imem_addr}, 32'd128);
    stall = 1'b0; auto_ack = 1'b1;
    tick();
    chk("r_c14_vld",  {31'd0, id_valid}, 32'd1);
    chk("r_c14_pc",   id_pc, 32'h0000_0204);
    chk("r_c14_ins",  id_instr, 32'hC0DE_0080);

    // Reset in the middle of WAIT
    stall = 1'b1; auto_ack = 1'b0;
    tick();
    chk("m_c15_vld",  {31'd0, id_valid}, 32'd1);
    chk("m_c15_pc",   id_pc, 32'h0000_0204);
    chk("m_c15_addr", {22'd0, imem_addr}, 32'd129);
    rst = 1'b1;
    tick();
    chk("m_rst_req",   {31'd0, imem_req}, 32'd0);
    chk("m_rst_vld",   {31'd0, id_valid}, 32'd0);
    chk("m_rst_pc",    id_pc, 32'd0);
    chk("m_rst_instr", id_instr, 32'd0);
    chk("m_rst_addr",  {22'd0, imem_addr}, 32'd0);
    rst = 1'b0; stall = 1'b0; auto_ack = 1'b1; #1;
    chk("m_re_req",  {31'd0, imem_req}, 32'd1);
    chk("m_re_addr", {22'd0, imem_addr}, 32'd0);
    tick();
    chk("m_re_pc",   id_pc, 32'd4);

    // fetch_pc wrap from 32'hFFFF_FFFC to 0
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("x_vld",   {31'd0, id_valid}, 32'd0);
    chk("x_addr",  {22'd0, imem_addr}, 32'h3FF);
    tick();
    chk("x_pc",    id_pc, 32'd0);
    chk("x_ins",   id_instr, 32'hC0DE_03FF);
    chk("x_addr0", {22'd0, imem_addr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of prefetch-queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-006 The block SHALL have port imem_addr, output, 10 bits: word address, equal to fetch_pc[11:2].
REQ-007 The block SHALL have port imem_ack, input, 1 bit: read data is valid this cycle.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-009 The block SHALL have port redirect, input, 1 bit: taken branch or jump from EX.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: branch target.
REQ-011 The block SHALL have port stall, input, 1 bit: ID cannot accept an instruction this cycle.
REQ-012 The block SHALL have port id_valid, output, 1 bit: id_pc and id_instr hold a valid instruction.
REQ-013 The block SHALL have port id_pc, output, 32 bits: fetch address + 4 (the IF/ID pc value).
REQ-014 The block SHALL have port id_instr, output, 32 bits: instruction word for ID.

Function
REQ-015 The FSM SHALL have exactly three states: REQ (may issue), WAIT (request outstanding), DROP (discarding a stale response).
REQ-016 In REQ, imem_req SHALL be high iff count + outstanding < DEPTH; imem_ack in the same cycle SHALL complete the request, giving one instruction per cycle from a zero-wait memory.
REQ-017 An unacknowledged request SHALL move the FSM to WAIT; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-018 On ack without redirect, imem_rdata and fetch_pc+4 SHALL be pushed, fetch_pc SHALL advance by 4 (wrapping 32'hFFFF_FFFC to 0), and the FSM SHALL return to REQ.
REQ-019 The queue head SHALL drive id_*; it SHALL pop when id_valid && !stall; while stall is high, id_* SHALL hold.
REQ-020 A push and a pop in the same cycle SHALL leave count unchanged; a push SHALL never occur when count == DEPTH (guaranteed by REQ-016).
REQ-021 On redirect, the block SHALL flush the queue (id_valid low next cycle) and load fetch_pc <= redirect_pc; redirect SHALL have priority over stall, ack and push.
REQ-022 A redirect while in WAIT with no ack that cycle SHALL go to DROP; in DROP, the next ack SHALL be discarded, imem_req SHALL be low, and the FSM SHALL then enter REQ.
REQ-023 Ack coincident with redirect SHALL discard the data and enter REQ.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 While rst is high: fetch_pc = RESET_PC, FSM = REQ, count = 0, pointers = 0, imem_req = 0, id_valid = 0, id_pc = 0, id_instr = 0.
REQ-026 imem_req SHALL first assert in the first cycle after rst deasserts; rst asserted mid-request SHALL abandon the request without waiting for ack.

Configuration
REQ-027 With FETCH_QUEUE_BYPASS_EN defined, an acked word arriving while the queue is empty and redirect is low SHALL appear on id_* in the same cycle, and it SHALL be pushed only if stall is high.
REQ-028 Without FETCH_QUEUE_BYPASS_EN, every acked word SHALL be pushed and SHALL appear on id_* no earlier than the next cycle.

Structure
REQ-029 Package cpu_pkg SHALL hold RESET_PC default, the 32-bit word width, the imem address width (10), and the FSM state enum.
REQ-030 Storage and pointers SHALL live in one sub-module, fetch_fifo (push, pop, flush, count, head data).

Verification
REQ-031 Reset release with zero-wait ack: imem_addr 0,1,2,3; id_pc 4,8,12,16 on consecutive cycles from cycle 2 (cycle 1 with BYPASS_EN).
REQ-032 stall held high and ack always high: exactly 4 requests issued, then imem_req stays 0; id_pc holds 4 until stall drops.
REQ-033 Ack delayed 3 cycles: imem_addr stable for 4 cycles; one push per ack.
REQ-034 Redirect to 32'h0000_0100 while in WAIT: the returning ack is discarded; the next imem_addr is 64; the next id_pc is 32'h104; no stale id_valid.
REQ-035 Redirect and ack in the same cycle with queue full and stall high: queue empty next cycle, and the fetch restarts at redirect_pc.
REQ-036 rst mid-WAIT: all outputs return to the reset values of REQ-025, and fetch restarts at RESET_PC.
